// File: rtl/prbs16_pkg.sv
// Shared types and constants for the PRBS16 (x^16+x^14+x^13+x^11+1) checker.
// States, tap lags, generator seed and the next-bit predictor.
package prbs16_pkg;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam int TAP_A = 11;
   localparam int TAP_B = 13;
   localparam int TAP_C = 14;
   localparam int TAP_D = 16;

   localparam logic [15:0] PRBS_SEED = 16'hACE1;

   // h[0] is the newest bit, so lag k lives at h[k-1].
   function automatic logic prbs16_pred(input logic [15:0] h);
      return h[TAP_A-1] ^ h[TAP_B-1] ^ h[TAP_C-1] ^ h[TAP_D-1];
   endfunction

endpackage

// File: rtl/prbs16_err_window.sv
// Error-burst window: opens on the first error, spans WINDOW valid bits,
// and flags when ERR_THRESH errors land inside it.
module prbs16_err_window
   import prbs16_pkg::*;
#(
   parameter int WINDOW     = 64,
   parameter int ERR_THRESH = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic valid,
   input  logic error,
   input  logic clear,
   output logic hit
);

   localparam int BW = $clog2(WINDOW + 1);
   localparam int EW = $clog2(ERR_THRESH + 1);
   localparam logic [BW-1:0] WIN_LEN = BW'(WINDOW);
   localparam logic [EW-1:0] THR     = EW'(ERR_THRESH);

   logic          active_q;
   logic [BW-1:0] bits_q;
   logic [EW-1:0] errs_q;
   logic [BW-1:0] bits_n;
   logic [EW-1:0] errs_n;

   always_comb begin
      bits_n = BW'(1);
      errs_n = EW'(1);
      if (active_q) begin
         bits_n = bits_q + 1'b1;
         errs_n = errs_q + EW'(error);
      end
   end

   assign hit = valid && error && (errs_n >= THR);

   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         active_q <= 1'b0;
         bits_q   <= '0;
         errs_q   <= '0;
      end else if (valid && (active_q || error)) begin
         if (hit || (bits_n == WIN_LEN)) begin
            active_q <= 1'b0;
            bits_q   <= '0;
            errs_q   <= '0;
         end else begin
            active_q <= 1'b1;
            bits_q   <= bits_n;
            errs_q   <= errs_n;
         end
      end
   end

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS16 receive checker with lock FSM and error window.
// Define PRBS16_CHECKER_ERRCNT_EN to build the saturating ERR_COUNT.
module prbs16_checker
   import prbs16_pkg::*;
#(
   parameter int LOCK_GOOD  = 32,
   parameter int ERR_THRESH = 4,
   parameter int WINDOW     = 64
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        DIN,
   input  logic        DIN_VALID,
   output logic        LOCKED,
   output logic        BIT_ERR,
   output logic        LOCK_LOST,
   output logic [15:0] ERR_COUNT
);

   localparam int GW = $clog2(LOCK_GOOD + 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD - 1);

   state_t        state_q;
   logic [15:0]   hist_q;
   logic [3:0]    fill_q;
   logic [GW-1:0] good_q;

   logic          pred;
   logic          miss;
   logic [15:0]   hist_din;
   logic          in_lock;
   logic          win_hit;

   assign pred     = prbs16_pred(hist_q);
   assign miss     = DIN ^ pred;
   assign hist_din = {hist_q[14:0], DIN};
   assign in_lock  = (state_q == ST_LOCK);

   prbs16_err_window #(
      .WINDOW     (WINDOW),
      .ERR_THRESH (ERR_THRESH)
   ) u_win (
      .CLK   (CLK),
      .RESET (RESET),
      .valid (DIN_VALID && in_lock),
      .error (miss),
      .clear (!in_lock),
      .hit   (win_hit)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_FILL;
         hist_q    <= '0;
         fill_q    <= '0;
         good_q    <= '0;
         LOCKED    <= 1'b0;
         BIT_ERR   <= 1'b0;
         LOCK_LOST <= 1'b0;
      end else begin
         BIT_ERR   <= 1'b0;
         LOCK_LOST <= 1'b0;
         if (DIN_VALID) begin
            unique case (state_q)
               ST_FILL: begin
                  hist_q <= hist_din;
                  fill_q <= fill_q + 1'b1;
                  if (fill_q == 4'd15) begin
                     state_q <= ST_ACQ;
                  end
               end
               ST_ACQ: begin
                  hist_q <= hist_din;
                  // All-zero history predicts zero forever; never trust it.
                  if (miss || (hist_din == 16'h0000)) begin
                     good_q <= '0;
                  end else if (good_q == GOOD_LAST) begin
                     good_q  <= '0;
                     state_q <= ST_LOCK;
                     LOCKED  <= 1'b1;
                  end else begin
                     good_q <= good_q + 1'b1;
                  end
               end
               ST_LOCK: begin
                  // Free-run on the prediction so one bad bit is one error.
                  hist_q  <= {hist_q[14:0], pred};
                  BIT_ERR <= miss;
                  if (win_hit) begin
                     state_q   <= ST_FILL;
                     fill_q    <= '0;
                     LOCKED    <= 1'b0;
                     LOCK_LOST <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_FILL;
                  fill_q  <= '0;
                  good_q  <= '0;
                  LOCKED  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PRBS16_CHECKER_ERRCNT_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ERR_COUNT <= '0;
      end else if (DIN_VALID && in_lock && miss &&
                   (ERR_COUNT != 16'hFFFF)) begin
         ERR_COUNT <= ERR_COUNT + 1'b1;
      end
   end
`else
   assign ERR_COUNT = 16'h0000;
`endif

endmodule

// File: doc/prbs16_checker.md
PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 SHALL have parameter LOCK_GOOD, default 32: consecutive matching bits required to declare lock.
REQ-002 SHALL have parameter ERR_THRESH, default 4: errors within one window that force loss of lock.
REQ-003 SHALL have parameter WINDOW, default 64: error-window length in valid bits.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port DIN  input  1  received serial bit, LSB-first output of the 16-bit PRBS generator.
REQ-007 SHALL have port DIN_VALID  input  1  DIN sampled only when high.
REQ-008 SHALL have port LOCKED  output  1  high while in LOCKED state.
REQ-009 SHALL have port BIT_ERR  output  1  one-cycle pulse per mismatching valid bit while LOCKED.
REQ-010 SHALL have port LOCK_LOST  output  1  one-cycle pulse on LOCKED->FILL transition.
REQ-011 SHALL have port ERR_COUNT  output  16  total bit errors since reset, saturating at 16'hFFFF.

Function
REQ-012 SHALL hold a 16-bit history H of accepted bits; predicted bit P = H(lag11) ^ H(lag13) ^ H(lag14) ^ H(lag16), i.e. s[n] = s[n-11]^s[n-13]^s[n-14]^s[n-16] (polynomial x^16+x^14+x^13+x^11+1).
REQ-013 SHALL implement states FILL, ACQUIRE, LOCKED; cycles with DIN_VALID low change no state, counter or history.
REQ-014 FILL: shift DIN into H; after 16 valid bits go to ACQUIRE on the next clock.
REQ-015 ACQUIRE: shift DIN into H; DIN==P increments good count, DIN!=P clears it; reaching LOCK_GOOD enters LOCKED.
REQ-016 ACQUIRE zero guard: if H is all-zero after the shift, good count SHALL be cleared (stuck-at-0 never locks).
REQ-017 LOCKED: shift P (not DIN) into H, so each corrupted bit counts exactly once; DIN!=P asserts BIT_ERR the following cycle.
REQ-018 Error window: first error in LOCKED opens a window of WINDOW valid bits (including the erroring bit); reaching ERR_THRESH errors inside it -> FILL, LOCK_LOST pulse, LOCKED low the same cycle; window expiry clears window error count.
REQ-019 ERR_COUNT SHALL increment with each BIT_ERR and SHALL hold at 16'hFFFF; it is not cleared on loss of lock.
REQ-020 Outputs registered; latency DIN-valid-edge to BIT_ERR/LOCK_LOST/LOCKED = 1 cycle.

Reset
REQ-021 RESET high SHALL, at the next CLK edge, force state FILL, H=0, all counters 0, LOCKED=0, BIT_ERR=0, LOCK_LOST=0, ERR_COUNT=0; RESET dominates DIN_VALID.
REQ-022 RESET mid-lock SHALL abandon lock without a LOCK_LOST pulse.

Configuration
REQ-023 Macro PRBS16_CHECKER_ERRCNT_EN defined: ERR_COUNT as REQ-019.
REQ-024 Macro undefined: ERR_COUNT tied to 16'h0000, counter logic absent; BIT_ERR, lock and window behaviour unchanged.

Structure
REQ-025 Package prbs16_pkg SHALL hold the state enum, tap-lag constants (11,13,14,16) and the generator reset seed 16'hACE1.
REQ-026 Window logic SHALL be sub-module prbs16_err_window (inputs: valid, error, clear; output: threshold hit).

Verification
REQ-027 Clean stream from generator seeded 16'hACE1, DIN_VALID always high -> LOCKED rises after 16+32 valid bits plus 1 cycle; no BIT_ERR over 70000 bits; ERR_COUNT=0.
REQ-028 Locked, invert 3 bits spaced 10 apart -> 3 BIT_ERR pulses, ERR_COUNT=3, LOCKED stays high.
REQ-029 Locked, invert 4 bits within 64 -> LOCK_LOST pulse on 4th, LOCKED low, relock after 48 further clean bits.
REQ-030 Locked, 3 errors, 70 clean bits, 3 errors -> no loss of lock (window expired), ERR_COUNT=6.
REQ-031 DIN held 0 for 1000 valid bits -> LOCKED never asserts; then DIN_VALID toggling every other cycle with clean stream -> lock after 48 valid bits.
REQ-032 RESET asserted while LOCKED with ERR_COUNT=5 -> next cycle all outputs 0, no LOCK_LOST pulse.
